// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep self-test sequencer: state codes and
// reference truth tables for common 2-input gates.
package gate_sweep_pkg;

    typedef logic [1:0] sweep_state_t;

    localparam sweep_state_t ST_IDLE   = 2'd0;
    localparam sweep_state_t ST_SETTLE = 2'd1;
    localparam sweep_state_t ST_SAMPLE = 2'd2;
    localparam sweep_state_t ST_DONE   = 2'd3;

    // Bit k is the gate output expected for input combination k.
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl_sweep_counter.sv
// Settle-time counter and input-combination index for the gate sweep.
// clear restarts a sweep, advance steps to the next combination.
module sweep_counter
    import gate_sweep_pkg::*;
#(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            advance,
    input  logic            settle_en,
    output logic            settle_done,
    output logic            last_combo,
    output logic [N_IN-1:0] combo
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] settle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            combo      <= '0;
        end else if (clear) begin
            settle_cnt <= '0;
            combo      <= '0;
        end else if (advance) begin
            settle_cnt <= '0;
            combo      <= combo + 1'b1;
        end else if (settle_en) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_combo  = (combo == {N_IN{1'b1}});

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps all gate input combinations, samples after a settle
// time and checks against EXPECT_TT. GATE_SWEEP_CAPTURE_EN builds the tt_out capture.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                   N_IN          = 2,
    parameter int                   SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECT_TT     = TT_AND
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      gate_in,
    input  logic                 gate_out,
    output logic [(1<<N_IN)-1:0] tt_out,
    output logic [1:0]           dbg_state
);

    localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

    sweep_state_t    state, state_nxt;
    logic            clear, advance, settle_en, settle_done, last_combo;
    logic [N_IN-1:0] combo;
    logic            mismatch;
    logic [N_IN:0]   err_nxt;

    sweep_counter #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .advance     (advance),
        .settle_en   (settle_en),
        .settle_done (settle_done),
        .last_combo  (last_combo),
        .combo       (combo)
    );

    // start is only looked at in IDLE, so a start while busy is simply dropped.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        advance   = 1'b0;
        settle_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_en = 1'b1;
                if (settle_done) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (last_combo) begin
                    state_nxt = ST_DONE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign mismatch = (gate_out != EXPECT_TT[combo]);
    assign err_nxt  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

    // pass is resolved on the final sample edge so it is already valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                err_cnt <= '0;
                pass    <= 1'b0;
            end else if (state == ST_SAMPLE) begin
                err_cnt <= err_nxt;
                if (last_combo) pass <= (err_nxt == '0);
            end
        end
    end

`ifdef GATE_SWEEP_CAPTURE_EN
    logic [(1<<N_IN)-1:0] tt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q <= '0;
        end else if (clear) begin
            tt_q <= '0;
        end else if (state == ST_SAMPLE) begin
            tt_q[combo] <= gate_out;
        end
    end

    assign tt_out = tt_q;
`else
    assign tt_out = '0;
`endif

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign gate_in   = busy ? combo : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: a cycle-indexed sweep model checked every cycle,
// plus directed scenarios with literal expectations (AND, stuck-at-1, glitches, inverter).
module tb_gate_sweep_ctrl;

    localparam int S     = 2;
    localparam int NC    = 4;
    localparam int TOTAL = NC * (S + 1);
`ifdef GATE_SWEEP_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT: default AND configuration ----------------
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [2:0] err_cnt;
    logic [1:0] gate_in;
    logic       gate_out;
    logic [3:0] tt_out;
    logic [1:0] dbg_state;

    int mode = 0;          // 0: real AND gate, 1: output stuck at 1
    bit glitch_en = 1'b0;  // corrupt gate_out during settle cycles only
    bit m_settle_now = 1'b0;

    assign gate_out = ((mode == 1) ? 1'b1 : (&gate_in)) ^ (glitch_en & m_settle_now);

    gate_sweep_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .gate_in   (gate_in),
        .gate_out  (gate_out),
        .tt_out    (tt_out),
        .dbg_state (dbg_state)
    );

    // ---------------- DUT: 1-input inverter, settle 1 ----------------
    logic       start_i = 1'b0;
    logic       busy_i, done_i, pass_i;
    logic [1:0] err_i;
    logic [0:0] gate_in_i;
    logic       gate_out_i;
    logic [1:0] tt_i;
    logic [1:0] dbg_i;

    assign gate_out_i = ~gate_in_i[0];

    gate_sweep_ctrl #(
        .N_IN          (1),
        .SETTLE_CYCLES (1),
        .EXPECT_TT     (2'b01)
    ) dut_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_i),
        .busy      (busy_i),
        .done      (done_i),
        .pass      (pass_i),
        .err_cnt   (err_i),
        .gate_in   (gate_in_i),
        .gate_out  (gate_out_i),
        .tt_out    (tt_i),
        .dbg_state (dbg_i)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sweep is described by its cycle index t (1 = first cycle after accept):
    // combination k occupies cycles k*(S+1)+1 .. (k+1)*(S+1), the last of which
    // is its sample cycle; done falls in cycle TOTAL+1.
    logic [3:0] exp_tt = 4'b1000;
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_errs = 0;
    logic [3:0] m_obs = '0;
    bit         m_pass = 1'b0;

    function automatic bit gate_fn(input int k);
        return (mode == 1) ? 1'b1 : (k == NC - 1);
    endfunction

    always @(negedge clk) begin
        int  k;
        bit  g;
        int  e_state;
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_errs   = 0;
            m_obs    = '0;
            m_pass   = 1'b0;
        end
        if (!m_active)               e_state = 0;
        else if (m_t == TOTAL + 1)   e_state = 3;
        else if (m_t % (S + 1) == 0) e_state = 2;
        else                         e_state = 1;

        chk("m_busy", int'(busy), int'(m_active));
        chk("m_done", int'(done), int'(m_active && m_t == TOTAL + 1));
        chk("m_state", int'(dbg_state), e_state);
        chk("m_err_cnt", int'(err_cnt), m_errs);
        chk("m_pass", int'(pass), int'(m_pass));
        chk("m_tt_out", int'(tt_out), CAP ? int'(m_obs) : 0);
        if (!m_active || m_t <= TOTAL)
            chk("m_gate_in", int'(gate_in), m_active ? (m_t - 1) / (S + 1) : 0);

        m_settle_now = m_active && (m_t <= TOTAL) && (m_t % (S + 1) != 0);

        if (rst_n) begin
            if (m_active) begin
                if (m_t <= TOTAL && m_t % (S + 1) == 0) begin
                    k = m_t / (S + 1) - 1;
                    g = gate_fn(k);
                    if (g != exp_tt[k]) m_errs++;
                    m_obs[k] = g;
                    if (m_t == TOTAL) m_pass = (m_errs == 0);
                end
                if (m_t == TOTAL + 1) m_active = 1'b0;
                else                  m_t++;
            end else if (start) begin
                m_active = 1'b1;
                m_t      = 1;
                m_errs   = 0;
                m_obs    = '0;
                m_pass   = 1'b0;
            end
        end
    end

    int done_seen = 0;
    always @(negedge clk) if (done) done_seen++;

    // ---------------- driver tasks ----------------
    task automatic sweep(input bit mid_pulse, output int done_rel, output int n_done);
        int base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base = cyc;
        if (mid_pulse) begin
            fork
                begin
                    repeat (4) @(posedge clk);
                    #1 start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            join_none
        end
        done_rel = -1;
        n_done   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_rel < 0) done_rel = cyc - base + 1;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc, nd, n0, base, gin1, gin3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_gate_in", int'(gate_in), 0);
        chk("rst_tt_out", int'(tt_out), 0);
        chk("rst_busy_i", int'(busy_i), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Real AND gate.
        mode = 0;
        sweep(1'b0, dc, nd);
        chk("and_done_cycle", dc, 13);
        chk("and_done_count", nd, 1);
        chk("and_pass", int'(pass), 1);
        chk("and_err_cnt", int'(err_cnt), 0);
        chk("and_tt_out", int'(tt_out), CAP ? 8 : 0);

        // Output stuck at 1: combos 0..2 mismatch.
        mode = 1;
        sweep(1'b0, dc, nd);
        chk("stuck_done_cycle", dc, 13);
        chk("stuck_err_cnt", int'(err_cnt), 3);
        chk("stuck_pass", int'(pass), 0);
        chk("stuck_tt_out", int'(tt_out), CAP ? 15 : 0);

        // Glitches during settle only must not matter.
        mode = 0;
        glitch_en = 1'b1;
        sweep(1'b0, dc, nd);
        glitch_en = 1'b0;
        chk("glitch_pass", int'(pass), 1);
        chk("glitch_err_cnt", int'(err_cnt), 0);

        // start pulsed in cycle 5 is ignored.
        sweep(1'b1, dc, nd);
        chk("busy_start_done_cycle", dc, 13);
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_pass", int'(pass), 1);

        // Reset in cycle 7 with two errors already counted.
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_err_before", int'(err_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_gate_in", int'(gate_in), 0);
        chk("abort_err_cnt", int'(err_cnt), 0);
        chk("abort_pass", int'(pass), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = done_seen;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_seen - n0, 0);
        mode = 0;
        sweep(1'b0, dc, nd);
        chk("after_abort_done_cycle", dc, 13);
        chk("after_abort_pass", int'(pass), 1);

        // start held high: back-to-back sweeps.
        n0 = done_seen;
        start = 1'b1;
        repeat (27) @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("held_start_dones", done_seen - n0, 2);
        chk("held_start_idle", int'(busy), 0);

        // Inverter, N_IN=1, settle 1.
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        base = cyc;
        dc = -1; nd = 0; gin1 = -1; gin3 = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cyc - base + 1 == 1) gin1 = int'(gate_in_i);
            if (cyc - base + 1 == 3) gin3 = int'(gate_in_i);
            if (done_i) begin
                nd++;
                if (dc < 0) dc = cyc - base + 1;
            end
        end
        chk("inv_done_cycle", dc, 5);
        chk("inv_done_count", nd, 1);
        chk("inv_gate_in_c1", gin1, 0);
        chk("inv_gate_in_c3", gin3, 1);
        chk("inv_pass", int'(pass_i), 1);
        chk("inv_err_cnt", int'(err_i), 0);
        chk("inv_tt_out", int'(tt_i), CAP ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-test sequencer for a combinational gate datapath such as the 2-input AND (x, y -> f).
- Drives every input combination onto the gate in ascending order.
- Waits a programmable settle time before sampling the gate output.
- Compares each sample against an expected truth table, counts mismatches, reports pass/fail with a start/done handshake.
- Sits between a top-level test driver and the gate under check, replacing hand-written stimulus sequences.

Parameters:
N_IN, 2, number of gate inputs; combinations swept = 2**N_IN; legal 1..4.
SETTLE_CYCLES, 2, clock cycles gate_in is held before gate_out is sampled; legal >= 1.
EXPECT_TT, 4'b1000, expected truth table, width 2**N_IN; bit k = expected gate_out for gate_in == k (AND default).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE.
busy  output  1  high from the cycle after start is accepted until DONE completes.
done  output  1  single-cycle pulse when a sweep finishes.
pass  output  1  1 when the last sweep had zero mismatches; held until the next start.
err_cnt  output  N_IN+1  mismatch count of the current or last sweep; saturates at 2**N_IN.
gate_in  output  N_IN  gate stimulus; for N_IN=2, gate_in[1]=x and gate_in[0]=y.
gate_out  input  1  gate result (f).
tt_out  output  2**N_IN  captured observed truth table (see Optional Feature).

Behaviour:
Reset (asynchronous, rst_n low):
- state=IDLE; busy=0, done=0, pass=0, err_cnt=0, gate_in=0, tt_out=0.
- Settle counter and combo index are cleared.
- Reset asserted mid-sweep aborts immediately. No done pulse. pass stays 0.

States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: gate_in=0.
  - start=1 -> SETTLE.
  - On that transition: combo=0, gate_in=0, settle_cnt=0, err_cnt=0, pass=0, tt_out=0.
- SETTLE: gate_in=combo. settle_cnt increments each cycle.
  - settle_cnt == SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (one cycle): gate_out is compared with EXPECT_TT[combo].
  - Mismatch -> err_cnt+1 (saturating).
  - combo == 2**N_IN-1 -> DONE.
  - Otherwise combo+1, gate_in updates to the new combo on the same edge, settle_cnt=0 -> SETTLE.
- DONE (one cycle): done=1; pass = (err_cnt==0), including the final SAMPLE's result. Next state IDLE.
- busy=1 in SETTLE, SAMPLE and DONE; 0 in IDLE.

Timing:
- Per combination: SETTLE_CYCLES+1 cycles.
- done is high in cycle 2**N_IN*(SETTLE_CYCLES+1)+1 after the start-accept edge; defaults give cycle 13.

Boundaries:
- start while busy is ignored; no restart, no queuing.
- start held high continuously: a new sweep begins on the cycle after DONE.
- Wrap-around: combo never exceeds 2**N_IN-1; the final combination goes to DONE, not to 0.
- gate_out is sampled only in SAMPLE. Glitches during SETTLE have no effect.

Optional Feature:
Macro: GATE_SWEEP_CAPTURE_EN.
- Defined: in SAMPLE, tt_out[combo] <= gate_out; tt_out holds the full observed truth table after done, until the next start.
- Undefined: the capture register is not built; tt_out is tied to 0. All other behaviour is identical.

Decomposition:
Shared package gate_sweep_pkg:
- State enum: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
- Default constants: expected truth tables for AND (4'b1000), OR (4'b1110), XOR (4'b0110).

One natural sub-module, sweep_counter:
- Holds the settle counter and combo index.
- Ports: clear, advance, settle_done, last_combo.
- The FSM, comparison, error count and capture stay in gate_sweep_ctrl.

Test Plan:
1. Defaults, real AND gate on gate_out; start pulse -> gate_in sweeps 0,1,2,3, each for 3 cycles; done in cycle 13; pass=1, err_cnt=0, tt_out=4'b1000 with macro.
2. gate_out stuck at 1 -> err_cnt=3, pass=0, tt_out=4'b1111 with macro.
3. start pulsed at cycle 5 of a sweep -> ignored; single done at cycle 13; gate_in order unaffected.
4. rst_n low at cycle 7 -> busy=0, gate_in=0, err_cnt=0 immediately; no done; next start runs a clean full sweep.
5. SETTLE_CYCLES=1, N_IN=1, EXPECT_TT=2'b01 (inverter) with an inverter on gate_out -> done at cycle 5, pass=1.
6. Build without GATE_SWEEP_CAPTURE_EN, scenario 1 -> tt_out stays 0; pass, done and err_cnt identical to scenario 1.
